// File: rtl/dmem_responder_pkg.sv
// Shared memory definitions for the CPU data-memory blocks: bus FSM encoding,
// read-latency bounds and default array depth.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_TURN  = 2'd2
    } bus_state_e;

    localparam int RD_LAT_MIN         = 1;
    localparam int RD_LAT_MAX         = 4;
    localparam int DMEM_DEPTH_DEFAULT = 1024;

    function automatic int clamp_lat(input int lat);
        if (lat < RD_LAT_MIN) return RD_LAT_MIN;
        if (lat > RD_LAT_MAX) return RD_LAT_MAX;
        return lat;
    endfunction

endpackage

// File: rtl/dmem_read_pipe.sv
// Fixed-depth (valid, data) delay line for read responses; flush drops every
// in-flight entry so nothing stale survives a store.
module dmem_read_pipe #(
    parameter int DEPTH = 1,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_vld,
    input  logic [W-1:0] in_data,
    output logic         head_vld_nxt,
    output logic         head_vld,
    output logic [W-1:0] head_data
);

    logic [DEPTH-1:0]        vld_pipe_q, vld_pipe_d;
    logic [DEPTH-1:0][W-1:0] data_pipe_q, data_pipe_d;

    always_comb begin
        vld_pipe_d     = '0;
        data_pipe_d    = data_pipe_q;
        vld_pipe_d[0]  = in_vld;
        data_pipe_d[0] = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            vld_pipe_d[i]  = vld_pipe_q[i-1];
            data_pipe_d[i] = data_pipe_q[i-1];
        end
        if (flush) vld_pipe_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_q  <= '0;
            data_pipe_q <= '0;
        end else begin
            vld_pipe_q  <= vld_pipe_d;
            data_pipe_q <= data_pipe_d;
        end
    end

    assign head_vld_nxt = vld_pipe_d[DEPTH-1];
    assign head_vld     = vld_pipe_q[DEPTH-1];
    assign head_data    = data_pipe_q[DEPTH-1];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder on a shared bidirectional bus: byte-lane stores,
// latency-pipelined reads, bus turnaround FSM, sticky range error and counters.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int          DEPTH_WORDS  = DMEM_DEPTH_DEFAULT,
    parameter int          READ_LATENCY = 1,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] dmem_addr,
    input  logic        dmem_wen,
    input  logic [3:0]  byte_en,
    inout  wire  [31:0] dmem_data,
    output logic        err_oob,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
);

    localparam int LAT = clamp_lat(READ_LATENCY);
    localparam int AW  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    logic [31:0]   mem_q [DEPTH_WORDS];
    logic [31:0]   word_idx;
    logic          in_range;
    logic [AW-1:0] mem_idx;
    logic [31:0]   rd_data;

    assign word_idx = (dmem_addr - BASE_ADDR) >> 2;
    assign in_range = (dmem_addr >= BASE_ADDR) && (word_idx < 32'(DEPTH_WORDS));
    assign mem_idx  = word_idx[AW-1:0];
    assign rd_data  = in_range ? mem_q[mem_idx] : 32'h0;

    // Array is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clk) begin
        if (dmem_wen && in_range) begin
            for (int i = 0; i < 4; i++)
                if (byte_en[i]) mem_q[mem_idx][8*i +: 8] <= dmem_data[8*i +: 8];
        end
    end

    logic [15:0] rd_count_q, rd_count_d, wr_count_q, wr_count_d;
    logic        err_oob_q, err_oob_d;

    always_comb begin
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        if (!dmem_wen && rd_count_q != 16'hFFFF) rd_count_d = rd_count_q + 16'd1;
        if (dmem_wen && wr_count_q != 16'hFFFF)  wr_count_d = wr_count_q + 16'd1;
        err_oob_d = err_oob_q | ~in_range;
    end

    logic        head_vld_nxt, head_vld;
    logic [31:0] head_data;

    dmem_read_pipe #(.DEPTH(LAT), .W(32)) u_pipe (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (dmem_wen),
        .in_vld       (~dmem_wen),
        .in_data      (rd_data),
        .head_vld_nxt (head_vld_nxt),
        .head_vld     (head_vld),
        .head_data    (head_data)
    );

    bus_state_e state_q, state_d;
    logic       bus_oe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rd_count_q <= '0;
            wr_count_q <= '0;
            err_oob_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
            err_oob_q  <= err_oob_d;
        end
    end

    // Decisions look at the head valid being loaded this edge, so DRIVE lines up
    // with the data's arrival; TURN passes through IDLE within the same edge.
    always_comb begin
        state_d = state_q;
        if (dmem_wen) begin
            state_d = ST_TURN;
        end else begin
            case (state_q)
                ST_IDLE:  if (head_vld_nxt) state_d = ST_DRIVE;
                ST_DRIVE: if (!head_vld_nxt) state_d = ST_IDLE;
                ST_TURN:  state_d = head_vld_nxt ? ST_DRIVE : ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        bus_oe = (state_q == ST_DRIVE) && head_vld && !dmem_wen;
    end

    assign dmem_data = bus_oe ? head_data : 32'hzzzz_zzzz;
    assign err_oob   = err_oob_q;
    assign rd_count  = rd_count_q;
    assign wr_count  = wr_count_q;

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL provide parameter DEPTH_WORDS, default 1024, meaning memory size in 32-bit words.
REQ-002 SHALL provide parameter READ_LATENCY, default 1, meaning cycles from read issue to drive; legal range 1..4.
REQ-003 SHALL provide parameter BASE_ADDR, default 32'h0000_0000, meaning byte address of word 0.
REQ-004 SHALL use one clock and an asynchronous active-low reset, ports named clk and rst_n.
REQ-005 Ports:
- clk  input  1  clock
- rst_n  input  1  async active-low reset
- dmem_addr  input  32  byte address from CPU
- dmem_wen  input  1  write enable; 0 means read request
- byte_en  input  4  byte lanes for stores
- dmem_data  inout  32  shared data bus
- err_oob  output  1  sticky out-of-range access flag
- rd_count  output  16  reads issued, saturating
- wr_count  output  16  writes accepted, saturating

Function
REQ-006 SHALL compute word index as (dmem_addr - BASE_ADDR) >> 2, ignoring dmem_addr[1:0]; in range iff dmem_addr >= BASE_ADDR and index < DEPTH_WORDS.
REQ-007 SHALL, at a rising edge with dmem_wen=1 and an in-range address, write dmem_data[8i+7:8i] into byte i of the word for each byte_en[i]=1, leaving other bytes unchanged.
REQ-008 SHALL treat byte_en=4'b0000 with dmem_wen=1 as an accepted write that changes no data and increments wr_count.
REQ-009 SHALL issue a read at every rising edge with dmem_wen=0, sampling the array word as committed by earlier edges.
REQ-010 SHALL pass each read through a READ_LATENCY-deep pipeline of (valid, data) entries; head entry drives the bus READ_LATENCY cycles after issue.
REQ-011 SHALL return 32'h0000_0000 for out-of-range reads, SHALL ignore out-of-range writes, and SHALL set err_oob on either; err_oob is cleared only by reset.
REQ-012 SHALL implement a bus FSM with states IDLE, DRIVE, TURN:
- IDLE -> DRIVE when pipeline head valid and dmem_wen=0.
- DRIVE -> IDLE when head becomes invalid.
- Any state -> TURN on an edge with dmem_wen=1.
- TURN -> IDLE after one edge with dmem_wen=0; TURN holds while dmem_wen=1.
REQ-013 SHALL drive dmem_data with head data only when state=DRIVE and dmem_wen=0, else high-Z; dmem_wen=1 SHALL release the bus combinationally, in the same cycle.
REQ-014 SHALL flush all valid pipeline entries on an edge with dmem_wen=1, so no stale read data is driven after a store.
REQ-015 SHALL let reads issued during TURN proceed normally.
REQ-016 SHALL increment rd_count per issued read and wr_count per accepted write, including out-of-range accesses, each saturating at 16'hFFFF.

Reset
REQ-017 SHALL, while rst_n=0 and independent of clk, force state=IDLE, all pipeline valids=0, dmem_data=high-Z, err_oob=0, rd_count=0, wr_count=0.
REQ-018 SHALL retain memory array contents across reset.
REQ-019 SHALL abandon any in-flight read when reset asserts mid-operation; no drive occurs after release until a new read completes.

Structure
REQ-020 SHALL place the FSM state encodings, the READ_LATENCY bounds and the DEPTH_WORDS default in the shared memory-definitions package used by the CPU memory blocks.
REQ-021 SHALL implement the latency pipeline as one sub-module, dmem_read_pipe, with flush and depth parameters.

Verification
REQ-022 Write 32'hDEADBEEF to 0x10 with byte_en=4'hF, then read 0x10 -> bus drives 32'hDEADBEEF exactly 1 cycle after issue (default latency).
REQ-023 Preload 0x20=32'h11223344, write byte_en=4'b0101 with data 32'hAABBCCDD, then read -> 32'h11BB33DD.
REQ-024 Issue read at 0x10, assert dmem_wen on the next cycle -> bus high-Z that cycle, no drive of stale data, one TURN cycle of high-Z before the next read data.
REQ-025 Read 0x1000 with DEPTH_WORDS=1024 -> 32'h0 driven, err_oob=1 until reset, rd_count incremented.
REQ-026 With READ_LATENCY=3, back-to-back reads of 0x0, 0x4, 0x8 -> data appears on cycles 3, 4, 5 after the first issue, in order.
REQ-027 Assert rst_n=0 mid-read, then release -> bus high-Z, counters 0, err_oob 0; earlier written word 0x10 still reads 32'hDEADBEEF.
